ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
- Request-side controller that sits directly upstream of the single-port RAM with a bidirectional data bus.
- Converts a valid/ready request stream into the RAM's cs / w_r1 / oe / address strobes.
- Owns the tristate driver on the shared data bus and returns read data through a valid/ready response channel.
- Guarantees the controller and the RAM never drive the bus at the same time.

Parameters:
- DATA_WIDTH, 8, width of the RAM data bus and of the request/response data.
- ADDR_WIDTH, 8, width of the RAM address.
- READ_LAT, 1, number of cycles cs/oe are held before read data is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data.
- mem_address  output  ADDR_WIDTH  to RAM address.
- mem_cs  output  1  to RAM cs.
- mem_w_r1  output  1  to RAM w_r1; 1 = write.
- mem_oe  output  1  to RAM oe.
- mem_data  inout  DATA_WIDTH  shared RAM data bus.
- rdback_err  output  1  read-back mismatch pulse (see Optional Feature).

Behaviour:
- Reset: one clock, asynchronous active-low (rst_n). While rst_n is low:
  - state = IDLE;
  - mem_cs, mem_w_r1, mem_oe, rsp_valid and rdback_err = 0;
  - mem_address, rsp_rdata and all latches = 0;
  - mem_data is released to high-Z immediately.
  - Reset asserted mid-operation aborts the operation; no response is produced.
- State machine: IDLE, WR, RD, RSP (plus VFY when the optional feature is compiled in).
- RAM strobes and mem_address are decoded from the state register and latched request fields only; no combinational path from req_* to mem_*.
- Bus drive rule: mem_data is driven with the latched wdata only when state == WR. In every other state mem_data is high-Z.
- IDLE:
  - req_ready = 1; all strobes 0.
  - On req_valid && req_ready, latch addr, we and wdata.
  - Next state is WR if we = 1, else RD. The read-latency counter is cleared.
- WR, exactly 1 cycle:
  - mem_cs = 1, mem_w_r1 = 1, mem_oe = 0, bus driven.
  - The RAM captures on the closing edge.
  - Next state is IDLE (VFY when the feature is enabled).
  - Writes produce no response.
- RD, READ_LAT cycles:
  - mem_cs = 1, mem_w_r1 = 0, mem_oe = 1.
  - The counter increments each cycle.
  - On the edge ending the last cycle, mem_data is sampled into rsp_rdata; next state is RSP.
- RSP:
  - All strobes 0, bus high-Z, rsp_valid = 1.
  - rsp_rdata is held stable until rsp_ready. On rsp_valid && rsp_ready, next state is IDLE.
  - This cycle is also the mandatory bus turnaround between a read and any following write.
- Latency:
  - Write: strobes assert in the cycle after acceptance; req_ready returns 2 cycles after the accept edge.
  - Read: rsp_valid rises READ_LAT+1 cycles after the accept edge.
  - Best-case read throughput is one request every READ_LAT+2 cycles.
- req_ready is 0 in every state except IDLE. A request presented at any other time is held by the source, not dropped.
- Address and data are latched, so req_* may change freely after acceptance.
- Sampling rule: if mem_data contains X or Z at the sample edge, the value is captured as-is; no masking.

Optional Feature:
- Macro: RAM_CTRL_RDBACK_EN.
- Defined:
  - After every WR, the controller enters VFY (1 cycle: mem_cs = 1, mem_w_r1 = 0, mem_oe = 1, bus high-Z), then re-enters RD logic with the same address.
  - The sampled word is compared with the latched wdata. A mismatch pulses rdback_err high for exactly 1 cycle.
  - No rsp_valid is produced for verify reads; the controller returns to IDLE.
  - Write latency becomes 3+READ_LAT cycles.
- Not defined: no VFY state; rdback_err is tied to 0; write timing is as above.

Test Plan:
1. Hold rst_n low for 3 cycles -> mem_cs / mem_w_r1 / mem_oe / rsp_valid / req_ready all 0 and mem_data high-Z; after release req_ready = 1.
2. Write 8'hA5 to addr 0, then read addr 0 (READ_LAT = 1) -> mem_cs && mem_w_r1 high for exactly 1 cycle with mem_data = A5; rsp_valid 2 cycles after read accept with rsp_rdata = 8'hA5.
3. Write 8'h3C to addr 1, immediately read addr 1 then addr 0 -> rsp_rdata 8'h3C then 8'hA5; mem_data never X from bus contention at any cycle.
4. Read with rsp_ready held low for 5 cycles -> rsp_valid stays 1, rsp_rdata stable, req_ready 0, strobes 0 throughout; one cycle after rsp_ready, req_ready = 1.
5. Assert rst_n mid-RD with READ_LAT = 4 -> mem_cs / mem_oe drop without waiting for clk; no rsp_valid after reset release.
6. With RAM_CTRL_RDBACK_EN defined: write 8'h5A with a good RAM model -> rdback_err stays 0. Repeat with the model's stored bit 0 forced -> rdback_err is a single 1-cycle pulse.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready front end for a single-port RAM with a shared bidirectional data bus.
// Optional build macro RAM_CTRL_RDBACK_EN adds a read-back verify of every write (rdback_err).
module ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_cs,
  output logic                  mem_w_r1,
  output logic                  mem_oe,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  rdback_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RSP
`ifdef RAM_CTRL_RDBACK_EN
    , VFY
`endif
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(READ_LAT - 1);

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;
  logic [3:0]              lat_cnt;
  logic                    rd_last;

  assign rd_last = (lat_cnt == LAST_CNT);

  // NOTE: every register below uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      lat_cnt   <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
          end
        end
        RD: begin
          lat_cnt <= lat_cnt + 4'd1;
          // A read phase that belongs to a write is a verify read and never updates the response.
          if (rd_last && !we_q) rsp_rdata <= mem_data;
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_CTRL_RDBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdback_err <= 1'b0;
    else        rdback_err <= (state == RD) && rd_last && we_q && (mem_data != wdata_q);
  end
`else
  assign rdback_err = 1'b0;
`endif

  // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
  always_comb begin
    next_state = state;
    mem_cs     = 1'b0;
    mem_w_r1   = 1'b0;
    mem_oe     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: if (req_valid) next_state = req_we ? WR : RD;
      WR: begin
        mem_cs   = 1'b1;
        mem_w_r1 = 1'b1;
`ifdef RAM_CTRL_RDBACK_EN
        next_state = VFY;
`else
        next_state = IDLE;
`endif
      end
`ifdef RAM_CTRL_RDBACK_EN
      VFY: begin
        mem_cs     = 1'b1;
        mem_oe     = 1'b1;
        next_state = RD;
      end
`endif
      RD: begin
        mem_cs = 1'b1;
        mem_oe = 1'b1;
        if (rd_last) next_state = we_q ? IDLE : RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Gated by rst_n because the state register already reads IDLE while reset is held.
  assign req_ready   = rst_n && (state == IDLE);
  assign mem_address = addr_q;
  // Only WR drives the bus; RSP doubles as the read-to-write turnaround cycle.
  assign mem_data    = (state == WR) ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed cases plus random traffic against an array model.
module tb_ram_ctrl;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RL = 3;
`ifdef RAM_CTRL_RDBACK_EN
  localparam int WR_LAT = 3 + RL;
`else
  localparam int WR_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, mem_cs, mem_w_r1, mem_oe, rdback_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_address;
  wire  [DW-1:0] mem_data;

  always #5 clk = ~clk;

  ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_cs(mem_cs), .mem_w_r1(mem_w_r1), .mem_oe(mem_oe),
    .mem_data(mem_data), .rdback_err(rdback_err)
  );

  // RAM model: drives the bus on reads, captures on the edge closing a write cycle.
  logic [DW-1:0] ram [256];
  logic          stuck = 1'b0;
  wire           ram_drive = mem_cs && mem_oe && !mem_w_r1;
  assign mem_data = ram_drive ? ram[mem_address] : 'z;
  always @(posedge clk)
    if (mem_cs && mem_w_r1) ram[mem_address] <= stuck ? (mem_data | DW'(1)) : mem_data;

  logic [DW-1:0] model [256];
  int checks = 0, failures = 0;
  int err_cycles = 0, err_expected = 0;

  always @(negedge clk) if (rdback_err) err_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic scramble_req();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic flt);
    int strobes = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; stuck = flt;
    wait_ready();
    @(posedge clk); #1;
    scramble_req();
    model[a] = flt ? (d | DW'(1)) : d;
    if (flt && !d[0]) err_expected++;
    for (int k = 1; k <= WR_LAT; k++) begin
      @(negedge clk);
      if (mem_cs && mem_w_r1) strobes++;
      if (k == 1) begin
        check("wr_cs", 32'(mem_cs), 32'd1);
        check("wr_w_r1", 32'(mem_w_r1), 32'd1);
        check("wr_oe", 32'(mem_oe), 32'd0);
        check("wr_addr", 32'(mem_address), 32'(a));
        check("wr_bus", 32'(mem_data), 32'(d));
      end
      check("wr_req_ready", 32'(req_ready), 32'(k == WR_LAT));
      check("wr_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("wr_strobe_cycles", 32'(strobes), 32'd1);
    stuck = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    logic [DW-1:0] exp;
    exp = model[a];
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = DW'($urandom); rsp_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    scramble_req();
    for (int k = 1; k <= RL; k++) begin
      @(negedge clk);
      check("rd_cs", 32'(mem_cs), 32'd1);
      check("rd_oe", 32'(mem_oe), 32'd1);
      check("rd_w_r1", 32'(mem_w_r1), 32'd0);
      check("rd_addr", 32'(mem_address), 32'(a));
      check("rd_early_valid", 32'(rsp_valid), 32'd0);
      check("rd_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp));
    check("rsp_cs", 32'(mem_cs), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", 32'(rsp_rdata), 32'(exp));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_strobes", 32'({mem_cs, mem_oe, mem_w_r1}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_done_valid", 32'(rsp_valid), 32'd0);
    check("rsp_done_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_strobes", 32'({mem_cs, mem_w_r1, mem_oe}), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_addr", 32'(mem_address), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed: write/read, back-to-back reads, stalled response.
    do_write(8'h00, 8'hA5, 1'b0);
    do_read(8'h00, 0);
    do_write(8'h01, 8'h3C, 1'b0);
    do_read(8'h01, 0);
    do_read(8'h00, 0);
    do_read(8'h01, 5);

    // Fill the remaining random-target addresses, then random traffic.
    for (int i = 2; i < 16; i++) do_write(AW'(i), DW'($urandom), 1'b0);
    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom), 1'b0);
      else                           do_read(a, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset asserted in the middle of a read.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05; rsp_ready = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    scramble_req();
    @(negedge clk);
    check("mid_rd_cs", 32'(mem_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cs", 32'(mem_cs), 32'd0);
    check("async_rst_oe", 32'(mem_oe), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < RL + 3; k++) begin
      @(negedge clk);
      check("post_abort_valid", 32'(rsp_valid), 32'd0);
    end
    check("post_abort_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;

`ifdef RAM_CTRL_RDBACK_EN
    do_write(8'h20, 8'h5A, 1'b0);
    do_write(8'h21, 8'h5A, 1'b1);
    do_read(8'h20, 0);
    do_read(8'h21, 0);
`endif
    repeat (3) @(negedge clk);
    check("rdback_err_cycles", 32'(err_cycles), 32'(err_expected));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
